// File: rtl/sp_loader_pkg.sv
// Shared types and constants for the shortest-path matrix loader.
package sp_loader_pkg;

    localparam int A_INIT_WIDTH   = 11;
    localparam int D_WIDTH        = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int D_INIT_WIDTH   = BYTES_PER_WORD * D_WIDTH;
    localparam int WORDS          = 2048;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        FLUSH  = 3'd2,
        LAUNCH = 3'd3,
        WAIT   = 3'd4,
        FINISH = 3'd5
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == LOAD) || (s == FLUSH) || (s == LAUNCH) || (s == WAIT);
    endfunction

endpackage

// File: rtl/sp_byte_packer.sv
// Packs a byte stream little-endian into words and emits a one-cycle word_valid pulse.
// With SP_LOADER_CHECKSUM_EN defined, the word being completed this cycle is exported as word_next.
module sp_byte_packer
    import sp_loader_pkg::*;
#(
    parameter int D_W   = sp_loader_pkg::D_WIDTH,
    parameter int LANES = sp_loader_pkg::BYTES_PER_WORD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 byte_valid,
    input  logic [D_W-1:0]       byte_in,
    output logic                 lane_last,
`ifdef SP_LOADER_CHECKSUM_EN
    output logic [LANES*D_W-1:0] word_next,
`endif
    output logic                 word_valid,
    output logic [LANES*D_W-1:0] word
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LW-1:0]             lane;
    logic [(LANES-1)*D_W-1:0]  partial;
    logic [LANES*D_W-1:0]      assembled;

    // Earlier bytes sit in the low lanes, so the arriving byte always tops the word.
    assign assembled = {byte_in, partial};
    assign lane_last = (lane == LW'(LANES - 1));

`ifdef SP_LOADER_CHECKSUM_EN
    assign word_next = assembled;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= '0;
            partial    <= '0;
            word_valid <= 1'b0;
            word       <= '0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane    <= '0;
                partial <= '0;
            end else if (byte_valid) begin
                if (lane_last) begin
                    word       <= assembled;
                    word_valid <= 1'b1;
                    lane       <= '0;
                end else begin
                    partial <= {byte_in, partial[(LANES-1)*D_W-1:D_W]};
                    lane    <= lane + LW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/sp_matrix_loader.sv
// Loads the distance matrix into M memory port B, then launches the engine and waits for Done.
// Define SP_LOADER_CHECKSUM_EN to add the Checksum output (sum of words written this run).
//
// state  | meaning
// IDLE   | after reset, waiting for Start
// LOAD   | accepting bytes, one port-B write per 4 bytes
// FLUSH  | final write on the bus; leave once the write strobe drops
// LAUNCH | Go pulse to the engine
// WAIT   | waiting for Done from the engine
// FINISH | Finished held; Start reloads from address 0
module sp_matrix_loader #(
    parameter int A_INIT_WIDTH = sp_loader_pkg::A_INIT_WIDTH,
    parameter int D_INIT_WIDTH = sp_loader_pkg::D_INIT_WIDTH,
    parameter int D_WIDTH      = sp_loader_pkg::D_WIDTH,
    parameter int WORDS        = sp_loader_pkg::WORDS
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Start,
    input  logic [D_WIDTH-1:0]      In_Data,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    output logic [A_INIT_WIDTH-1:0] M_Addr_B,
    output logic [D_INIT_WIDTH-1:0] M_Out_B,
    output logic                    M_En_B,
    output logic                    M_We_B,
    output logic                    Go,
    input  logic                    Done,
    output logic                    Busy,
`ifdef SP_LOADER_CHECKSUM_EN
    output logic [D_INIT_WIDTH-1:0] Checksum,
`endif
    output logic                    Finished
);

    import sp_loader_pkg::*;

    localparam int BPW = D_INIT_WIDTH / D_WIDTH;

    state_t                  state;
    state_t                  next_state;
    logic                    accept;
    logic                    start_hit;
    logic                    last_byte;
    logic                    last_word;
    logic                    lane_last;
    logic                    word_valid;
    logic [D_INIT_WIDTH-1:0] word;
    logic [A_INIT_WIDTH-1:0] word_idx;
    logic                    ready_d;
    logic                    busy_d;
    logic                    go_d;
    logic                    finished_d;
`ifdef SP_LOADER_CHECKSUM_EN
    logic [D_INIT_WIDTH-1:0] word_next;
`endif

    assign accept    = In_Valid && In_Ready;
    assign start_hit = Start && ((state == IDLE) || (state == FINISH));
    assign last_byte = accept && lane_last;
    assign last_word = (word_idx == A_INIT_WIDTH'(WORDS - 1));

    sp_byte_packer #(
        .D_W   (D_WIDTH),
        .LANES (BPW)
    ) u_packer (
        .clk        (Clk),
        .rst        (Rst),
        .clear      (start_hit),
        .byte_valid (accept),
        .byte_in    (In_Data),
        .lane_last  (lane_last),
`ifdef SP_LOADER_CHECKSUM_EN
        .word_next  (word_next),
`endif
        .word_valid (word_valid),
        .word       (word)
    );

    assign M_En_B  = word_valid;
    assign M_We_B  = word_valid;
    assign M_Out_B = word;

    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (Start) next_state = LOAD;
            LOAD:    if (last_byte && last_word) next_state = FLUSH;
            FLUSH:   if (!word_valid) next_state = LAUNCH;
            LAUNCH:  next_state = WAIT;
            WAIT:    if (Done) next_state = FINISH;
            FINISH:  if (Start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Decoded from next_state so the registered outputs line up with the state they describe.
    always_comb begin
        ready_d    = (next_state == LOAD);
        busy_d     = is_busy(next_state);
        go_d       = (next_state == LAUNCH);
        finished_d = (next_state == FINISH);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            In_Ready <= 1'b0;
            Busy     <= 1'b0;
            Go       <= 1'b0;
            Finished <= 1'b0;
            M_Addr_B <= '0;
            word_idx <= '0;
        end else begin
            In_Ready <= ready_d;
            Busy     <= busy_d;
            Go       <= go_d;
            Finished <= finished_d;
            if (start_hit) begin
                word_idx <= '0;
            end else if (last_byte) begin
                M_Addr_B <= word_idx;
                if (!last_word) word_idx <= word_idx + A_INIT_WIDTH'(1);
            end
        end
    end

`ifdef SP_LOADER_CHECKSUM_EN
    always_ff @(posedge Clk) begin
        if (Rst)            Checksum <= '0;
        else if (start_hit) Checksum <= '0;
        else if (last_byte) Checksum <= Checksum + word_next;
    end
`endif

endmodule

// File: tb/tb_sp_matrix_loader.sv
// Directed bench for sp_matrix_loader: reset, single word, reset mid-load, full-rate and bubbly streams.
module tb_sp_matrix_loader;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [7:0]  In_Data;
    logic        In_Valid;
    logic        In_Ready;
    logic [10:0] M_Addr_B;
    logic [31:0] M_Out_B;
    logic        M_En_B;
    logic        M_We_B;
    logic        Go;
    logic        Done;
    logic        Busy;
    logic        Finished;
`ifdef SP_LOADER_CHECKSUM_EN
    logic [31:0] Checksum;
`endif

    int checks   = 0;
    int failures = 0;

    int          cyc = 0;
    int          wr_count;
    int          acc_count;
    int          bad_writes;
    int          go_count;
    int          last_wr_cyc;
    int          go_cyc;
    logic [31:0] mem [0:2047];

    sp_matrix_loader dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .In_Data  (In_Data),
        .In_Valid (In_Valid),
        .In_Ready (In_Ready),
        .M_Addr_B (M_Addr_B),
        .M_Out_B  (M_Out_B),
        .M_En_B   (M_En_B),
        .M_We_B   (M_We_B),
        .Go       (Go),
        .Done     (Done),
        .Busy     (Busy),
`ifdef SP_LOADER_CHECKSUM_EN
        .Checksum (Checksum),
`endif
        .Finished (Finished)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // SRAM model plus bookkeeping; writes must be sequential and each backed by 4 accepted bytes.
    always @(negedge Clk) begin
        if (M_En_B && M_We_B) begin
            if (M_Addr_B != 11'(wr_count) || acc_count < 4 * (wr_count + 1)) bad_writes++;
            mem[M_Addr_B] = M_Out_B;
            wr_count++;
            last_wr_cyc = cyc;
        end
        if (Go) begin
            go_count++;
            go_cyc = cyc;
        end
        if (In_Valid && In_Ready) acc_count++;
    end

    function automatic logic [31:0] expected_word(input int n);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4 * n + k);
        return w;
    endfunction

    function automatic logic [31:0] expected_sum();
        logic [31:0] s = '0;
        for (int n = 0; n < 2048; n++) s = s + expected_word(n);
        return s;
    endfunction

    function automatic int mem_errs();
        int e = 0;
        for (int n = 0; n < 2048; n++) if (mem[n] !== expected_word(n)) e++;
        return e;
    endfunction

    task automatic clear_mon();
        wr_count   = 0;
        acc_count  = 0;
        bad_writes = 0;
        go_count   = 0;
        last_wr_cyc = 0;
        go_cyc     = 0;
        for (int n = 0; n < 2048; n++) mem[n] = 32'hDEAD_BEEF;
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
    endtask

    task automatic apply_reset();
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
    endtask

    // Byte value = stream index mod 256; returns bytes accepted and cycles used.
    task automatic stream_bytes(input int nbytes, input bit bubbles, input int done_at,
                                output int sent, output int cycles, output int stalls);
        bit acc;
        sent = 0; cycles = 0; stalls = 0;
        while (sent < nbytes && cycles < 4 * nbytes + 100) begin
            In_Valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
            In_Data  = 8'(sent);
            Done     = (cycles == done_at);
            @(negedge Clk);
            acc = In_Valid && In_Ready;
            if (!bubbles && !In_Ready) stalls++;
            @(posedge Clk); #1;
            if (acc) sent++;
            cycles++;
        end
        In_Valid = 1'b0;
        Done     = 1'b0;
    endtask

    task automatic wait_go_then_done(input string tag);
        int waited = 0;
        while (go_count == 0 && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        checks++;
        if (go_count !== 1) begin
            $display("FAIL %s_go_seen: go_count=%0d required 1", tag, go_count);
            failures++;
        end
        checks++;
        if (go_cyc - last_wr_cyc !== 2) begin
            $display("FAIL %s_go_lag: lag=%0d cycles required 2", tag, go_cyc - last_wr_cyc);
            failures++;
        end
        @(posedge Clk); #1;
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if (go_count !== 1 || Busy !== 1'b1 || Finished !== 1'b0) begin
            $display("FAIL %s_wait_state: go_count=%0d busy=%b finished=%b required 1 1 0",
                     tag, go_count, Busy, Finished);
            failures++;
        end
        @(posedge Clk); #1;
        repeat (95) @(posedge Clk);
        #1;
        Done = 1'b1;
        @(posedge Clk); #1;
        Done = 1'b0;
        @(negedge Clk);
        checks++;
        if (Finished !== 1'b1 || Busy !== 1'b0 || In_Ready !== 1'b0) begin
            $display("FAIL %s_finish: finished=%b busy=%b ready=%b required 1 0 0",
                     tag, Finished, Busy, In_Ready);
            failures++;
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; In_Valid = 1'b0; In_Data = '0; Done = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if ({In_Ready, M_En_B, M_We_B, Go, Busy, Finished} !== 6'b0 ||
            M_Addr_B !== 11'd0 || M_Out_B !== 32'd0) begin
            $display("FAIL reset_outputs: rdy/en/we/go/busy/fin=%b addr=%0h data=%0h required all 0",
                     {In_Ready, M_En_B, M_We_B, Go, Busy, Finished}, M_Addr_B, M_Out_B);
            failures++;
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        Done = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        Done = 1'b0;
        @(negedge Clk);
        checks++;
        if (In_Ready !== 1'b0 || Busy !== 1'b0 || Finished !== 1'b0) begin
            $display("FAIL idle_hold: ready=%b busy=%b finished=%b required 0 0 0",
                     In_Ready, Busy, Finished);
            failures++;
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_first_word();
        clear_mon();
        pulse_start();
        @(negedge Clk);
        checks++;
        if (In_Ready !== 1'b1 || Busy !== 1'b1) begin
            $display("FAIL load_entry: ready=%b busy=%b required 1 1", In_Ready, Busy);
            failures++;
        end
        @(posedge Clk); #1;
        for (int b = 1; b <= 4; b++) begin
            In_Data  = 8'(b);
            In_Valid = 1'b1;
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0;
        @(negedge Clk);
        checks++;
        if (M_En_B !== 1'b1 || M_We_B !== 1'b1 || M_Out_B !== 32'h0403_0201 || M_Addr_B !== 11'd0) begin
            $display("FAIL first_word: en=%b we=%b addr=%0h data=%h required 1 1 0 04030201",
                     M_En_B, M_We_B, M_Addr_B, M_Out_B);
            failures++;
        end
        @(posedge Clk); #1;
        @(negedge Clk);
        checks++;
        if (M_En_B !== 1'b0 || wr_count !== 1) begin
            $display("FAIL first_word_width: en=%b writes=%0d required 0 1", M_En_B, wr_count);
            failures++;
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid();
        int sent, cycles, stalls;
        apply_reset();
        clear_mon();
        pulse_start();
        stream_bytes(10, 1'b0, -1, sent, cycles, stalls);
        Rst = 1'b1;
        @(posedge Clk); #1;
        @(negedge Clk);
        checks++;
        if (In_Ready !== 1'b0 || Busy !== 1'b0 || M_En_B !== 1'b0 || sent !== 10) begin
            $display("FAIL mid_reset_outputs: ready=%b busy=%b en=%b sent=%0d required 0 0 0 10",
                     In_Ready, Busy, M_En_B, sent);
            failures++;
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        @(negedge Clk);
        checks++;
        if (wr_count !== 2 || go_count !== 0 || In_Ready !== 1'b0 || bad_writes !== 0) begin
            $display("FAIL mid_reset_after: writes=%0d go=%0d ready=%b bad=%0d required 2 0 0 0",
                     wr_count, go_count, In_Ready, bad_writes);
            failures++;
        end
        checks++;
        if (mem[1] !== expected_word(1)) begin
            $display("FAIL mid_reset_word1: got %h required %h", mem[1], expected_word(1));
            failures++;
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_full_rate();
        int sent, cycles, stalls;
        apply_reset();
        clear_mon();
        pulse_start();
        stream_bytes(8192, 1'b0, 100, sent, cycles, stalls);
        checks++;
        if (sent !== 8192 || cycles !== 8192 || stalls !== 0) begin
            $display("FAIL full_rate_stream: sent=%0d cycles=%0d stalls=%0d required 8192 8192 0",
                     sent, cycles, stalls);
            failures++;
        end
        @(negedge Clk);
        checks++;
        if (In_Ready !== 1'b0 || Finished !== 1'b0) begin
            $display("FAIL full_rate_ready_drop: ready=%b finished=%b required 0 0", In_Ready, Finished);
            failures++;
        end
        @(negedge Clk);
        checks++;
        if (wr_count !== 2048 || bad_writes !== 0) begin
            $display("FAIL full_rate_writes: writes=%0d bad=%0d required 2048 0", wr_count, bad_writes);
            failures++;
        end
        checks++;
        if (mem_errs() !== 0) begin
            $display("FAIL full_rate_contents: bad_words=%0d required 0", mem_errs());
            failures++;
        end
`ifdef SP_LOADER_CHECKSUM_EN
        checks++;
        if (Checksum !== expected_sum()) begin
            $display("FAIL full_rate_checksum: got %h required %h", Checksum, expected_sum());
            failures++;
        end
`endif
        wait_go_then_done("full_rate");
    endtask

    task automatic test_bubbles_reload();
        int sent, cycles, stalls;
        clear_mon();
        pulse_start();
        @(negedge Clk);
        checks++;
        if (In_Ready !== 1'b1 || Finished !== 1'b0 || Busy !== 1'b1) begin
            $display("FAIL reload_entry: ready=%b finished=%b busy=%b required 1 0 1",
                     In_Ready, Finished, Busy);
            failures++;
        end
`ifdef SP_LOADER_CHECKSUM_EN
        checks++;
        if (Checksum !== 32'd0) begin
            $display("FAIL reload_checksum_clear: got %h required 0", Checksum);
            failures++;
        end
`endif
        @(posedge Clk); #1;
        stream_bytes(8192, 1'b1, -1, sent, cycles, stalls);
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (sent !== 8192 || wr_count !== 2048 || bad_writes !== 0) begin
            $display("FAIL bubbles_writes: sent=%0d writes=%0d bad=%0d required 8192 2048 0",
                     sent, wr_count, bad_writes);
            failures++;
        end
        checks++;
        if (mem_errs() !== 0) begin
            $display("FAIL bubbles_contents: bad_words=%0d required 0", mem_errs());
            failures++;
        end
`ifdef SP_LOADER_CHECKSUM_EN
        checks++;
        if (Checksum !== expected_sum()) begin
            $display("FAIL bubbles_checksum: got %h required %h", Checksum, expected_sum());
            failures++;
        end
`endif
        wait_go_then_done("bubbles");
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_first_word();
        test_reset_mid();
        test_full_rate();
        test_bubbles_reload();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
